// File: rtl/asmd_pkg.sv
// asmd_pkg: state encodings and sizing shared by the ASMD multiplier and divider.
package asmd_pkg;
  typedef enum logic {S_IDLE, S_DIVIDE} state_t;
  localparam int DEF_WORD_LENGTH = 8;
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/asmd_div_step.sv
// asmd_div_step: one restoring-division iteration on {rem, q}.
module asmd_div_step #(
  parameter int N = 8
) (
  input  logic [N:0]   rem_i,
  input  logic [N-1:0] q_i,
  input  logic [N-1:0] div_i,
  output logic [N:0]   rem_o,
  output logic [N-1:0] q_o
);
  logic [N:0] sh;
  logic       ge;
  // rem stays below div, so its top bit is always zero and can be shifted out
  assign sh    = {rem_i[N-1:0], q_i[N-1]};
  assign ge    = sh >= {1'b0, div_i};
  assign rem_o = ge ? sh - {1'b0, div_i} : sh;
  assign q_o   = {q_i[N-2:0], ge};
endmodule

// File: rtl/asmd_divider.sv
// asmd_divider: sequential restoring divider, 2N-bit dividend by N-bit divisor,
// one quotient bit per clock with a start/ready handshake.
module asmd_divider
  import asmd_pkg::*;
#(
  parameter int word_length = DEF_WORD_LENGTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [2*word_length-1:0]   dividend,
  input  logic [word_length-1:0]     divisor,
  input  logic                       start,
  output logic [word_length-1:0]     quotient,
  output logic [word_length-1:0]     remainder,
  output logic                       overflow,
  output logic                       ready
);
  localparam int N  = word_length;
  localparam int CW = cnt_width(N);
  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N:0]     rem_q, rem_d, rem_n;
  logic [N-1:0]   qr_q, qr_d, q_n;
  logic [N-1:0]   div_q, div_d;
  logic [N-1:0]   quot_q, quot_d, remo_q, remo_d;
  logic           ovf_q, ovf_d, ovf_c;
  assign ovf_c = dividend[2*N-1:N] >= divisor;
  asmd_div_step #(.N(N)) u_step (
    .rem_i(rem_q),
    .q_i  (qr_q),
    .div_i(div_q),
    .rem_o(rem_n),
    .q_o  (q_n)
  );
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    qr_d    = qr_q;
    div_d   = div_q;
    quot_d  = quot_q;
    remo_d  = remo_q;
    ovf_d   = ovf_q;
    if (state_q == S_IDLE) begin
      if (start && ovf_c) begin
        quot_d = '1;
        remo_d = '0;
        ovf_d  = 1'b1;
      end else if (start) begin
        rem_d   = {1'b0, dividend[2*N-1:N]};
        qr_d    = dividend[N-1:0];
        div_d   = divisor;
        cnt_d   = CW'(N);
        ovf_d   = 1'b0;
        state_d = S_DIVIDE;
      end
    end else begin
      rem_d = rem_n;
      qr_d  = q_n;
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == CW'(1)) begin
        state_d = S_IDLE;
        quot_d  = q_n;
        remo_d  = rem_n[N-1:0];
      end
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      qr_q    <= '0;
      div_q   <= '0;
      quot_q  <= '0;
      remo_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      qr_q    <= qr_d;
      div_q   <= div_d;
      quot_q  <= quot_d;
      remo_q  <= remo_d;
      ovf_q   <= ovf_d;
    end
  end
  assign quotient  = quot_q;
  assign remainder = remo_q;
  assign overflow  = ovf_q;
  assign ready     = state_q == S_IDLE;
endmodule

// File: tb/tb_asmd_divider.sv
// tb_asmd_divider: directed and random checks of asmd_divider against a scoreboard.
module tb_asmd_divider;
  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       ovf;
  } exp_t;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] dividend = '0;
  logic [7:0]  divisor = '0;
  logic        start = 1'b0;
  logic [7:0]  quotient, remainder;
  logic        overflow, ready;
  int cmp = 0;
  int bad = 0;
  exp_t sb[$];
  logic [15:0] last_dd;
  logic [7:0]  last_dv;

  asmd_divider #(.word_length(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .dividend (dividend),
    .divisor  (divisor),
    .start    (start),
    .quotient (quotient),
    .remainder(remainder),
    .overflow (overflow),
    .ready    (ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic [15:0] dd, input logic [7:0] dv);
    exp_t e;
    @(negedge clk);
    dividend = dd;
    divisor  = dv;
    start    = 1'b1;
    last_dd  = dd;
    last_dv  = dv;
    e.ovf = (dd >> 8) >= 16'(dv);
    e.q   = e.ovf ? 8'hFF : 8'((dd / 16'(dv)));
    e.r   = e.ovf ? 8'h00 : 8'((dd % 16'(dv)));
    sb.push_back(e);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Called #1 after the accepting edge; busy cycles are counted for non-overflow ops.
  task automatic wait_done(input string tag, input int busy_before);
    exp_t e;
    int cyc;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 1, 0);
      return;
    end
    e = sb.pop_front();
    if (e.ovf) begin
      chk({tag, "_ready_ovf"}, ready, 1);
    end else begin
      chk({tag, "_ready_low"}, ready, 0);
      cyc = busy_before;
      while (!ready && cyc < 20) begin
        @(posedge clk);
        #1 cyc++;
      end
      chk({tag, "_latency"}, cyc, 8);
    end
    chk({tag, "_q"}, quotient, e.q);
    chk({tag, "_r"}, remainder, e.r);
    chk({tag, "_ovf"}, overflow, e.ovf);
  endtask

  initial begin
    // reset asserted mid-clock
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("rst_ready", ready, 1);
    chk("rst_q", quotient, 0);
    chk("rst_r", remainder, 0);
    chk("rst_ovf", overflow, 0);
    @(negedge clk) reset = 1'b0;

    start_op(16'h0064, 8'h07);
    wait_done("basic", 0);

    start_op(16'hFEFF, 8'hFF);
    wait_done("max", 0);

    start_op(16'h0500, 8'h05);
    wait_done("ovf", 0);

    start_op(16'h1234, 8'h00);
    wait_done("div0", 0);

    // start with new operands while busy must be ignored
    start_op(16'h0064, 8'h07);
    @(posedge clk);
    #1 dividend = 16'h0500;
    divisor = 8'h03;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done("busy", 2);

    // reset during the 4th busy cycle aborts the operation
    start_op(16'h0100, 8'h03);
    repeat (3) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("abort_ready", ready, 1);
    chk("abort_q", quotient, 0);
    chk("abort_r", remainder, 0);
    chk("abort_ovf", overflow, 0);
    sb.delete();
    @(negedge clk) reset = 1'b0;
    start_op(16'h0100, 8'h03);
    wait_done("post_abort", 0);

    // round trip: 13*11 divided by 11
    start_op(16'(13 * 11), 8'd11);
    wait_done("rt", 0);

    for (int i = 0; i < 200; i++) begin
      logic [7:0] dv, qq, rr;
      logic [15:0] dd;
      dv = 8'($urandom_range(1, 255));
      qq = 8'($urandom_range(0, 255));
      rr = 8'($urandom_range(0, int'(dv) - 1));
      dd = 16'(qq) * 16'(dv) + 16'(rr);
      start_op(dd, dv);
      wait_done("rand", 0);
      chk("rand_inv", 32'(quotient) * 32'(last_dv) + 32'(remainder), 32'(last_dd));
      chk("rand_rlt", remainder < last_dv, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule

// File: doc/asmd_divider.md
Name: asmd_divider

Overview:
- Sequential restoring divider built as an ASMD (state machine plus datapath); the inverse of asmd_multiplier.
- Takes a 2*word_length-bit dividend, the same width as the multiplier's product, and a word_length-bit divisor.
- Produces a word_length-bit quotient and remainder, one quotient bit per clock.
- Uses the same start/ready handshake as asmd_multiplier, so the two blocks can be chained for multiply/divide round trips.

Parameters:
- word_length, 8, operand width N; dividend is 2N bits; quotient and remainder are N bits.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high reset.
- dividend  input  2*word_length  numerator; sampled only on an accepted start.
- divisor  input  word_length  denominator; sampled only on an accepted start.
- start  input  1  request; accepted only on a rising edge where ready=1.
- quotient  output  word_length  result; held until the next accepted start.
- remainder  output  word_length  result; held until the next accepted start.
- overflow  output  1  quotient does not fit in N bits (includes divide-by-zero).
- ready  output  1  high when idle; results are valid whenever ready=1 after a completed operation.

Behaviour:
- Reset (async, immediate): state=S_IDLE, ready=1, quotient=0, remainder=0, overflow=0, counter=0.
- States: S_IDLE, S_DIVIDE. Moore ready: 1 in S_IDLE, 0 in S_DIVIDE.
- Overflow check, combinational at start: overflow condition = dividend[2N-1:N] >= divisor. This also covers divisor==0.
- Accepted start with overflow (edge k):
  - stay in S_IDLE; ready stays 1.
  - quotient = all ones, remainder = 0, overflow = 1; visible after edge k.
  - no cycles consumed.
- Accepted start without overflow (edge k):
  - load rem_reg (N+1 bits) = {1'b0, dividend[2N-1:N]}, q_reg = dividend[N-1:0], div_reg = divisor.
  - counter = N; overflow = 0; state -> S_DIVIDE; ready=0 after edge k.
- Each edge in S_DIVIDE:
  - shift {rem_reg, q_reg} left by 1.
  - if shifted rem >= {1'b0, div_reg}: rem -= div_reg and q lsb = 1; else q lsb = 0.
  - counter decrements.
- Completion: on the edge where counter reaches 0 (edge k+N):
  - state -> S_IDLE, ready=1.
  - quotient = q_reg, remainder = rem_reg[N-1:0]. Bit N is guaranteed 0 here.
- Latency: ready is low for exactly N cycles; results are visible after edge k+N.
- quotient/remainder outputs update only on completion or on an overflow accept. They never show intermediate values.
- start while in S_DIVIDE is ignored: no restart, operands not resampled.
- start held high continuously: a new operation is accepted on the first edge with ready=1, i.e. back-to-back with no gap cycle.
- Input changes during S_DIVIDE have no effect.
- Reset during S_DIVIDE aborts the operation; all outputs return to reset values immediately.
- Unsigned arithmetic only; no rounding.
- Invariant when overflow=0: dividend == quotient*divisor + remainder, with remainder < divisor.

Decomposition:
- Shared package asmd_pkg (Verilog header or SV package) used by multiplier and divider:
  - state encodings S_IDLE, S_DIVIDE.
  - default word_length.
  - counter width = $clog2(word_length+1).
- One combinational sub-module, asmd_div_step: takes rem (N+1), q (N), div (N); returns next rem and next q for one restoring iteration.
- The top level holds the FSM, counter and registers.

Test Plan (N=8):
- Reset: assert reset mid-clock -> immediately ready=1, quotient=0, remainder=0, overflow=0.
- Basic: dividend=0x0064, divisor=0x07, one-cycle start -> ready low exactly 8 cycles, then quotient=0x0E, remainder=0x02, overflow=0.
- Max non-overflow: dividend=0xFEFF, divisor=0xFF -> quotient=0xFF, remainder=0xFE after 8 cycles.
- Overflow and divide-by-zero:
  - dividend=0x0500, divisor=0x05 -> ready never drops; overflow=1, quotient=0xFF, remainder=0x00 next cycle.
  - dividend=0x1234, divisor=0x00 -> same response.
- Busy/abort:
  - pulse start with new operands during S_DIVIDE -> original result 0x0064/0x07 unchanged.
  - assert reset at cycle 4 of an operation -> outputs zero, ready=1; a subsequent start works normally.
- Round trip with asmd_multiplier: word0=13, word1=11 -> product=143 -> divide 143 by 11 -> quotient=13, remainder=0. Repeat for 200 random non-overflow pairs, checking the invariant.
